// File: rtl/ir_fetch_ctrl_if.sv
// ir_fetch_ctrl_if: fetch bus between the fetch requester and instruction memory / decode
//   o_addr  : instruction memory word address (master -> slave)
//   o_req   : read enable for o_addr this cycle
//   o_pc    : address tag of the word currently presented to decode
//   o_valid : the word at decode is architecturally valid
interface ir_fetch_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] o_addr;
    logic              o_req;
    logic [ADDR_W-1:0] o_pc;
    logic              o_valid;

    modport master (output o_addr, o_req, o_pc, o_valid);
    modport slave  (input  o_addr, o_req, o_pc, o_valid);
endinterface

// File: rtl/ir_fetch_ctrl.sv
// ir_fetch_ctrl: instruction fetch requester with 2-cycle tag pipeline, stall hold and redirect squash
//   clk, rst      : clock, synchronous active-high reset
//   stall         : pipeline stall (same signal the IR cache controller sees)
//   redirect      : branch/jump taken this cycle, target on redirect_pc
//   bus (master)  : o_addr/o_req to instruction memory, o_pc/o_valid to decode
//   o_bubble_cnt  : saturating count of invalid decode cycles when IR_FETCH_PERF_EN is defined, else 0
module ir_fetch_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    ir_fetch_ctrl_if.master   bus,
    output logic [15:0]       o_bubble_cnt
);
    logic [ADDR_W-1:0] pc_r, pc_next, d1_pc, d2_pc, hold_pc;
    logic              run_r, req, valid;
    logic              d1_valid, d2_valid, hold_valid;
    logic              stall_1_r, stall_2_r;

    // rst gates the request so the memory sees no read during a mid-run reset
    always_comb begin
        req     = run_r & ~stall & ~rst;
        pc_next = redirect ? redirect_pc : req ? pc_r + ADDR_W'(1) : pc_r;
        valid   = stall_2_r ? hold_valid : d2_valid;
    end

    // d1/d2 track the 2-cycle memory latency; a redirect kills both younger fetches
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            run_r      <= 1'b0;
            d1_pc      <= '0;
            d1_valid   <= 1'b0;
            d2_pc      <= '0;
            d2_valid   <= 1'b0;
            stall_1_r  <= 1'b0;
            stall_2_r  <= 1'b0;
            hold_pc    <= '0;
            hold_valid <= 1'b0;
        end else begin
            pc_r      <= pc_next;
            run_r     <= 1'b1;
            d1_pc     <= pc_r;
            d1_valid  <= req & ~redirect;
            d2_pc     <= d1_pc;
            d2_valid  <= d1_valid & ~redirect;
            stall_1_r <= stall;
            stall_2_r <= stall_1_r;
            if (!stall_2_r) begin
                hold_pc    <= d2_pc;
                hold_valid <= d2_valid;
            end
        end
    end

    assign bus.o_addr  = pc_r;
    assign bus.o_req   = req;
    assign bus.o_pc    = stall_2_r ? hold_pc : d2_pc;
    assign bus.o_valid = valid;

`ifdef IR_FETCH_PERF_EN
    logic [15:0] bubble_r;

    always_ff @(posedge clk) begin
        if (rst)
            bubble_r <= '0;
        else if (!valid && bubble_r != 16'hFFFF)
            bubble_r <= bubble_r + 16'd1;
    end

    assign o_bubble_cnt = bubble_r;
`else
    assign o_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// tb_ir_fetch_ctrl: directed self-checking bench for ir_fetch_ctrl (RESET_PC = 0x0100)
module tb_ir_fetch_ctrl;
`ifdef IR_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] bubble;
    int          tests = 0;
    int          fails = 0;

    ir_fetch_ctrl_if #(.ADDR_W(16)) bus ();

    ir_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0100)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .bus(bus),
        .o_bubble_cnt(bubble)
    );

    always #5 clk = ~clk;

    // advance one cycle, drive inputs just after the edge, sample 2 time units later
    task automatic cyc(input logic st, input logic rd, input logic [15:0] rp);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = st;
        redirect = rd;
        redirect_pc = rp;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (bus.o_addr !== 16'h0100) begin fails++; $display("FAIL reset_addr got %h exp 0100", bus.o_addr); end
        tests++;
        if (bus.o_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", bus.o_req); end
        tests++;
        if (bus.o_pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h exp 0000", bus.o_pc); end
        tests++;
        if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
        tests++;
        if (bubble !== 16'h0000) begin fails++; $display("FAIL reset_bubble got %h exp 0000", bubble); end
    endtask

    task automatic test_startup(input string tag);
        for (int c = 0; c < 6; c++) begin
            logic        er, ev;
            logic [15:0] ea, ep;
            cyc(1'b0, 1'b0, 16'h0);
            er = (c >= 1);
            ea = (c == 0) ? 16'h0100 : 16'(16'h00FF + c);
            ev = (c >= 3);
            ep = 16'(16'h00FD + c);
            tests++;
            if ({bus.o_req, bus.o_addr} !== {er, ea}) begin
                fails++; $display("FAIL %s_req_addr c%0d got %b/%h exp %b/%h", tag, c, bus.o_req, bus.o_addr, er, ea);
            end
            tests++;
            if (bus.o_valid !== ev || (ev && bus.o_pc !== ep)) begin
                fails++; $display("FAIL %s_valid_pc c%0d got %b/%h exp %b/%h", tag, c, bus.o_valid, bus.o_pc, ev, ep);
            end
            if (c == 3) begin
                tests++;
                if (bubble !== (PERF ? 16'd3 : 16'd0)) begin
                    fails++; $display("FAIL %s_bubble got %0d exp %0d", tag, bubble, PERF ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 8; k++) begin
            logic        er;
            logic [15:0] ea, ep;
            cyc(k < 3, 1'b0, 16'h0);
            er = (k >= 3);
            ea = (k <= 3) ? 16'h0105 : 16'(16'h0102 + k);
            ep = (k == 0) ? 16'h0103 : (k <= 4) ? 16'h0104 : 16'(16'h0100 + k);
            tests++;
            if ({bus.o_req, bus.o_addr} !== {er, ea}) begin
                fails++; $display("FAIL stall_req_addr k%0d got %b/%h exp %b/%h", k, bus.o_req, bus.o_addr, er, ea);
            end
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_pc !== ep) begin
                fails++; $display("FAIL stall_valid_pc k%0d got %b/%h exp 1/%h", k, bus.o_valid, bus.o_pc, ep);
            end
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            tests++;
            if ({bus.o_addr, bus.o_valid, bus.o_pc} !== {16'(16'h010A + i), 1'b1, 16'(16'h0108 + i)}) begin
                fails++; $display("FAIL run_addr_pc i%0d got %h/%b/%h exp %h/1/%h", i, bus.o_addr, bus.o_valid, bus.o_pc, 16'(16'h010A + i), 16'(16'h0108 + i));
            end
        end
        for (int j = 0; j < 5; j++) begin
            logic        ev;
            logic [15:0] ea, ep;
            cyc(1'b0, j == 0, 16'h2000);
            ea = (j == 0) ? 16'h0110 : 16'(16'h1FFF + j);
            ev = (j != 1 && j != 2);
            ep = (j == 0) ? 16'h010E : 16'(16'h1FFD + j);
            tests++;
            if ({bus.o_req, bus.o_addr} !== {1'b1, ea}) begin
                fails++; $display("FAIL redirect_req_addr j%0d got %b/%h exp 1/%h", j, bus.o_req, bus.o_addr, ea);
            end
            tests++;
            if (bus.o_valid !== ev || (ev && bus.o_pc !== ep)) begin
                fails++; $display("FAIL redirect_valid_pc j%0d got %b/%h exp %b/%h", j, bus.o_valid, bus.o_pc, ev, ep);
            end
            if (j == 3) begin
                tests++;
                if (bubble !== (PERF ? 16'd5 : 16'd0)) begin
                    fails++; $display("FAIL redirect_bubble got %0d exp %0d", bubble, PERF ? 5 : 0);
                end
            end
        end
    endtask

    task automatic test_redirect_in_stall();
        for (int s = 0; s < 7; s++) begin
            logic        er;
            logic [15:0] ea, ep;
            cyc(s < 3, s == 1, 16'h0300);
            er = (s >= 3);
            ea = (s < 2) ? 16'h2004 : (s <= 3) ? 16'h0300 : 16'(16'h02FD + s);
            ep = (s == 0) ? 16'h2002 : (s <= 4) ? 16'h2003 : 16'(16'h02FB + s);
            tests++;
            if ({bus.o_req, bus.o_addr} !== {er, ea}) begin
                fails++; $display("FAIL stall_redirect_req_addr s%0d got %b/%h exp %b/%h", s, bus.o_req, bus.o_addr, er, ea);
            end
            tests++;
            if (bus.o_valid !== 1'b1 || bus.o_pc !== ep) begin
                fails++; $display("FAIL stall_redirect_valid_pc s%0d got %b/%h exp 1/%h", s, bus.o_valid, bus.o_pc, ep);
            end
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 6; r++) begin
            logic        ev;
            logic [15:0] ea, ep;
            cyc(1'b0, r == 0, 16'hFFFE);
            ea = (r == 0) ? 16'h0304 : 16'(32'hFFFD + r);
            ev = (r != 1 && r != 2);
            ep = (r == 0) ? 16'h0302 : 16'(32'hFFFB + r);
            tests++;
            if ({bus.o_req, bus.o_addr} !== {1'b1, ea}) begin
                fails++; $display("FAIL wrap_req_addr r%0d got %b/%h exp 1/%h", r, bus.o_req, bus.o_addr, ea);
            end
            tests++;
            if (bus.o_valid !== ev || (ev && bus.o_pc !== ep)) begin
                fails++; $display("FAIL wrap_valid_pc r%0d got %b/%h exp %b/%h", r, bus.o_valid, bus.o_pc, ev, ep);
            end
            if (r == 3) begin
                tests++;
                if (bubble !== (PERF ? 16'd7 : 16'd0)) begin
                    fails++; $display("FAIL wrap_bubble got %0d exp %0d", bubble, PERF ? 7 : 0);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        tests++;
        if (bus.o_req !== 1'b0) begin fails++; $display("FAIL midreset_req_in_rst got %b exp 0", bus.o_req); end
        @(posedge clk);
        #2;
        tests++;
        if ({bus.o_addr, bus.o_req, bus.o_valid} !== {16'h0100, 1'b0, 1'b0}) begin
            fails++; $display("FAIL midreset_state got %h/%b/%b exp 0100/0/0", bus.o_addr, bus.o_req, bus.o_valid);
        end
        tests++;
        if (bubble !== 16'h0000) begin fails++; $display("FAIL midreset_bubble got %h exp 0000", bubble); end
        test_startup("restart");
    endtask

    task automatic test_bubble_sat();
        repeat (65540) cyc(1'b0, 1'b1, 16'h0);
        tests++;
        if (bubble !== (PERF ? 16'hFFFF : 16'h0000)) begin
            fails++; $display("FAIL bubble_sat got %h exp %h", bubble, PERF ? 16'hFFFF : 16'h0000);
        end
        cyc(1'b0, 1'b1, 16'h0);
        tests++;
        if (bubble !== (PERF ? 16'hFFFF : 16'h0000)) begin
            fails++; $display("FAIL bubble_sat_hold got %h exp %h", bubble, PERF ? 16'hFFFF : 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_startup("startup");
        test_stall();
        test_redirect();
        test_redirect_in_stall();
        test_wrap();
        test_mid_reset();
        test_bubble_sat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ir_fetch_ctrl.md
# ir_fetch_ctrl

Instruction fetch requester for the 16-bit core. It owns the program counter and issues word addresses to the instruction memory, which has a fixed 2-cycle read latency. It carries a PC/valid tag alongside each in-flight read so the decode stage knows which address the returning instruction word belongs to. On stall it holds its outputs with the same 2-cycle-delayed hold timing as the IR cache controller on the data-return side. Branch redirects squash in-flight fetches.

## Interface
- `ADDR_W`, default 16: width of the PC and the instruction memory word address.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset. There is one clock in this block.
- `stall` input, 1: pipeline stall, the same signal delivered to the IR cache controller.
- `redirect` input, 1: branch or jump taken this cycle.
- `redirect_pc` input, ADDR_W: target address; sampled when `redirect`=1.
- `o_addr` output, ADDR_W: instruction memory read address, equal to `pc_r`.
- `o_req` output, 1: memory read enable for `o_addr` this cycle.
- `o_pc` output, ADDR_W: address of the instruction word currently presented to decode.
- `o_valid` output, 1: the instruction word at decode is architecturally valid.
- `o_bubble_cnt` output, 16: count of invalid decode cycles (see Configuration).

## Operation
- Registers:
  - `pc_r`, reset value RESET_PC.
  - `run_r`, reset 0; becomes 1 on the first cycle after reset and stays 1.
  - Tag stages `d1` and `d2`, each holding a pc and a valid bit; reset to pc 0, valid 0.
  - `stall_1_r` and `stall_2_r`, reset 0.
  - `hold_pc` and `hold_valid`, reset 0.
- `o_req = run_r & ~stall` (combinational).
- PC next-state, in priority order:
  - `redirect`: load `redirect_pc`.
  - `o_req`: increment by 1, wrapping modulo 2^ADDR_W (0xFFFF goes to 0x0000).
  - Otherwise: hold.
- Tag pipeline advances every cycle, mirroring the memory latency:
  - `d1 <= {pc_r, o_req & ~redirect}`.
  - `d2 <= {d1.pc, d1.valid & ~redirect}`.
- Squash rule: a redirect in cycle t invalidates the fetch issued in t and the one issued in t-1. The word returning in t (issued in t-2) is unaffected; this is the branch shadow that decode has already accepted.
- Stall delay: `stall_1_r <= stall` and `stall_2_r <= stall_1_r`.
- Output hold:
  - `hold_{pc,valid} <= d2` when `stall_2_r`=0; otherwise they hold.
  - When `stall_2_r`=1, `o_pc`/`o_valid` = `hold_*`. Otherwise they are driven from `d2`.
- Redirect has priority over stall. A redirect while stalled still loads the PC and squashes.
- Reset mid-operation clears all tags and the PC within one cycle. `o_req`=0 during reset and on the first cycle after it.
- Reset output values: `o_addr`=RESET_PC, `o_req`=0, `o_pc`=0, `o_valid`=0, `o_bubble_cnt`=0.

## Timing
- An address is issued in cycle t. Its tag appears on `o_pc`/`o_valid` in t+2, aligned with `i_data` at the IR cache controller.
- After reset deassertion (first non-reset cycle = c0):
  - c1 is the first `o_req`, for address RESET_PC.
  - c3 is the first `o_valid`=1.
- Stall asserted over cycles ts..te-1:
  - Reads in that window are not requested (`o_req`=0). Their returns fall inside the `stall_2_r` window ts+2..te+1 and are never exposed.
  - The tag issued at ts-1 is held on the outputs through te+1.
  - The held PC is issued at te and presented at te+2, so the decode sequence has no gaps or duplicates.
- Redirect in cycle t: `o_valid`=0 in t+1 and t+2. The target is issued at t+1 and presented with `o_valid`=1 at t+3, provided there is no stall.

## Configuration
- `IR_FETCH_PERF_EN` defined:
  - `o_bubble_cnt` is a 16-bit counter, reset to 0.
  - It increments in every non-reset cycle with `o_valid`=0.
  - It saturates at 0xFFFF.
- Not defined: `o_bubble_cnt` is tied to 0 and no counter register exists.

## Test plan
- Reset release with RESET_PC=0x0100 and no stall or redirect -> `o_addr` 0x0100, 0x0101, 0x0102 starting at c1; `o_pc`=0x0100 with `o_valid`=1 at c3; then +1 per cycle.
- Stall high for 3 cycles starting when `o_addr`=0x0105 -> `o_req`=0 for 3 cycles; `o_pc` holds 0x0104 for 4 cycles (ts+1..te+1); then 0x0105, 0x0106 with no gap.
- Redirect to 0x2000 while `o_addr`=0x0110 -> `o_valid`=0 for 2 cycles; then `o_pc`=0x2000 with `o_valid`=1, followed by 0x2001.
- Redirect to 0x0300 in the middle of a stall -> PC loads 0x0300 immediately; the first valid `o_pc` after the stall window is 0x0300.
- PC at 0xFFFE, free-running -> `o_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- With `IR_FETCH_PERF_EN`: reset, then one redirect -> `o_bubble_cnt`=3 after startup (c0, c1, c2 are invalid), then 5 after the redirect. Also force the count to saturate -> it stays at 0xFFFF. Without the macro -> the output is constantly 0.
